prefetch_fetch_unit: RTL and testbench
======================================

# prefetch_fetch_unit

Parametrised instruction fetch stage with a decoupled prefetch queue. It issues in-order instruction requests ahead of decode, tracks outstanding requests with credits, and discards stale responses after a redirect. It presents queue-head instructions to the decode boundary register. It sits between the instruction memory port and decode, and replaces the single-register fetch stage.

## Interface
- DEPTH, 4: prefetch queue entries and maximum outstanding requests; power of 2, ≥2.
- CW, $clog2(DEPTH+1): counter width, derived; do not override.

- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- controlReset  in  1  trap redirect to trapVector.
- branchValid  in  1  resolved-branch redirect.
- branchData  in  32  resolved-branch target.
- branchPredictValid  in  1  predictor redirect for the current queue head.
- branchPredictData  in  32  predicted target.
- fetchDecodeControl  in  control  stall/flush for the decode boundary register.
- instructionRequest  out  1  request valid.
- instructionAddress  out  32  request address (fetch PC).
- instructionReady  in  1  memory accepts the request when high with instructionRequest.
- instructionDataValid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance.
- instructionData  in  32  response word.
- headValid  out  1  queue non-empty.
- headProgramCounter  out  32  queue-head PC, for the predictor.
- headInstruction  out  32  queue-head instruction, for the predictor.
- fetchDecodePayload  out  fetchDecodePayload  decode boundary register.

## Operation
- State: fetchPC, responsePC, queue (DEPTH × {instruction, PC}), outstanding O, discard D (D ≤ O), payload.
- Redirect priority: reset > controlReset > branchValid > predict. A predict is taken only when branchPredictValid && headValid && !stall && no higher redirect.
- Request: instructionRequest = !redirect && (O + count < DEPTH). On acceptance: fetchPC += 4 and O++.
- Response: O--. If D>0, drop it and D--. Otherwise push {instructionData, responsePC} and responsePC += 4. In a redirect cycle, every response is dropped.
- Redirect to target T: fetchPC ← T; responsePC ← T; queue cleared; D ← O − instructionDataValid; O ← O − instructionDataValid.
- Payload update:
  - If flush: valid ← 0.
  - Else if !stall and headValid: load head {instruction, PC, PC+4}, set valid ← 1, pop.
  - Else if !stall: valid ← 0.
  - Else (stall): hold.
- Predict cycle: the head moves into the payload as above, and the rest of the queue is cleared.
- branchValid and controlReset do not clear the payload themselves. The hazard unit asserts flush with them.
- controlReset additionally zeroes the payload.
- Simultaneous push and pop at full: allowed. Push at full: impossible by credit; covered by an assertion.

## Timing
- Reset values:
  - fetchPC and responsePC = resetVector.
  - O = D = 0, queue empty.
  - payload = '0, instructionRequest = 0 during reset.
  - headValid = 0, headProgramCounter = 0, headInstruction = 0.
- Latency:
  - Response at cycle N is at the queue head in N+1 and in the payload in N+2.
  - There is no bypass.
- Redirect at cycle N:
  - The request from the new target can be issued at N+1.
  - The first new-path instruction reaches the payload no earlier than N+3, with 1-cycle memory latency.
- Stall holds the payload and the queue head. Requests continue until credits are exhausted.
- All arithmetic is modulo 2^32. The counters never wrap, by construction.

## Structure
- pack: control, fetchDecodePayload, resetVector, trapVector, plus a new typedef fetchQueueEntry {instruction, programCounter}.
- Sub-module prefetch_queue: a synchronous FIFO of fetchQueueEntry with push, pop, clear, count, and head outputs; DEPTH parameter. Pointer wrap uses an extra MSB.
- The top level holds the PCs, the O/D counters, redirect arbitration, and the payload register.

## Test plan
- Straight-line run, DEPTH=4, memory latency 2, no stall:
  - Requests issue at resetVector, +4, +8, …
  - The payload receives consecutive PCs, one per cycle after fill.
- Decode stall for 10 cycles, memory always ready:
  - Exactly 4 requests are outstanding or queued.
  - instructionRequest is held low.
  - After the stall, the payload delivers resetVector+0..+12 in order with no loss.
- branchValid to 0x100 with 3 requests outstanding:
  - D = 3, and the next 3 responses are dropped.
  - The next request address is 0x100.
  - The next payload PC is 0x100.
- branchPredictValid on head PC 0x40, target 0x200, queue holding 0x44/0x48:
  - The payload gets 0x40.
  - The queue is cleared.
  - The next payload PC is 0x200.
- controlReset coinciding with a response and branchValid:
  - The response is dropped.
  - fetchPC = trapVector.
  - The payload is '0.
  - branchData is ignored.
- reset asserted mid-run with 2 requests outstanding:
  - All state returns to reset values.
  - Late responses after reset release are pushed (O = 0 assumption). The bench holds memory idle across reset.

Source files
------------

// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared types and vectors for the prefetch fetch stage and its queue.
package prefetch_fetch_unit_pkg;

  localparam logic [31:0] resetVector = 32'h0000_0000;
  localparam logic [31:0] trapVector  = 32'h0000_0080;

  typedef struct packed {
    logic stall;
    logic flush;
  } Control;

  typedef struct packed {
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
  } FetchDecodePayload;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] programCounter;
  } FetchQueueEntry;

  typedef enum logic [1:0] {
    RedirectNone,
    RedirectTrap,
    RedirectBranch,
    RedirectPredict
  } RedirectKind;

endpackage

// File: rtl/prefetch_fetch_unit_queue.sv
// Prefetch FIFO of fetched {instruction, PC} pairs; pointers carry an extra
// wrap bit so full and empty are distinguishable without a separate counter.
module prefetch_queue
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  FetchQueueEntry pushEntry,
  output FetchQueueEntry headEntry,
  output logic           headValid,
  output logic [CW-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  FetchQueueEntry storage [DEPTH];
  logic [AW:0]    writePointer;
  logic [AW:0]    readPointer;
  logic [AW:0]    occupancy;
  logic           doPop;
  logic           full;

  assign occupancy = writePointer - readPointer;
  assign count     = CW'(occupancy);
  assign headValid = occupancy != '0;
  assign full      = occupancy == (AW + 1)'(DEPTH);
  assign doPop     = pop && headValid;
  assign headEntry = headValid ? storage[readPointer[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      writePointer <= '0;
      readPointer  <= '0;
    end else begin
      if (push) writePointer <= writePointer + (AW + 1)'(1);
      if (doPop) readPointer <= readPointer + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) storage[writePointer[AW-1:0]] <= pushEntry;
  end

  // Credits bound outstanding plus queued entries, so a push can never find the queue full.
  assert property (@(posedge clock) disable iff (reset) !(push && !clear && full && !doPop));

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Fetch stage with credit-limited prefetch: issues requests ahead of decode,
// drops responses made stale by redirects, and feeds the decode boundary register.
module prefetch_fetch_unit
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              controlReset,
  input  logic              branchValid,
  input  logic [31:0]       branchData,
  input  logic              branchPredictValid,
  input  logic [31:0]       branchPredictData,
  input  Control            fetchDecodeControl,
  output logic              instructionRequest,
  output logic [31:0]       instructionAddress,
  input  logic              instructionReady,
  input  logic              instructionDataValid,
  input  logic [31:0]       instructionData,
  output logic              headValid,
  output logic [31:0]       headProgramCounter,
  output logic [31:0]       headInstruction,
  output FetchDecodePayload fetchDecodePayload
);

  localparam logic [CW:0] creditLimit = (CW + 1)'(DEPTH);

  logic [31:0]    fetchPC;
  logic [31:0]    responsePC;
  logic [31:0]    redirectTarget;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  queueCount;
  logic [CW:0]    creditsUsed;
  RedirectKind    redirectKind;
  logic           redirect;
  logic           accept;
  logic           push;
  logic           pop;
  logic           stall;
  logic           flush;
  FetchQueueEntry headEntry;
  FetchQueueEntry pushEntry;

  assign stall = fetchDecodeControl.stall;
  assign flush = fetchDecodeControl.flush;

  // A prediction only counts when the head it predicts for is actually leaving this cycle.
  always_comb begin
    redirectKind   = RedirectNone;
    redirectTarget = fetchPC;
    if (controlReset) begin
      redirectKind   = RedirectTrap;
      redirectTarget = trapVector;
    end else if (branchValid) begin
      redirectKind   = RedirectBranch;
      redirectTarget = branchData;
    end else if (branchPredictValid && headValid && !stall) begin
      redirectKind   = RedirectPredict;
      redirectTarget = branchPredictData;
    end
  end

  assign redirect           = redirectKind != RedirectNone;
  assign creditsUsed        = {1'b0, outstanding} + {1'b0, queueCount};
  assign instructionRequest = !reset && !redirect && (creditsUsed < creditLimit);
  assign instructionAddress = fetchPC;
  assign accept             = instructionRequest && instructionReady;
  assign push               = instructionDataValid && !redirect && (discard == '0);
  assign pop                = (redirectKind != RedirectTrap) && !flush && !stall;
  assign pushEntry          = '{instruction: instructionData, programCounter: responsePC};
  assign headProgramCounter = headEntry.programCounter;
  assign headInstruction    = headEntry.instruction;

  prefetch_queue #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) queue (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (redirect),
    .pushEntry(pushEntry),
    .headEntry(headEntry),
    .headValid(headValid),
    .count    (queueCount)
  );

  // On redirect every request still in flight becomes a response to throw away.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPC     <= resetVector;
      responsePC  <= resetVector;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetchPC     <= redirectTarget;
      responsePC  <= redirectTarget;
      outstanding <= outstanding - CW'(instructionDataValid);
      discard     <= outstanding - CW'(instructionDataValid);
    end else begin
      if (accept) fetchPC <= fetchPC + 32'd4;
      if (push) responsePC <= responsePC + 32'd4;
      outstanding <= outstanding + CW'(accept) - CW'(instructionDataValid);
      if (instructionDataValid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || controlReset) begin
      fetchDecodePayload <= '0;
    end else if (flush) begin
      fetchDecodePayload.valid <= 1'b0;
    end else if (!stall) begin
      if (headValid) begin
        fetchDecodePayload <= '{valid:               1'b1,
                                instruction:         headEntry.instruction,
                                programCounter:      headEntry.programCounter,
                                programCounterPlus4: headEntry.programCounter + 32'd4};
      end else begin
        fetchDecodePayload.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Bench for prefetch_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_prefetch_fetch_unit;
  import prefetch_fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              controlReset = 1'b0;
  logic              branchValid = 1'b0;
  logic [31:0]       branchData = '0;
  logic              branchPredictValid = 1'b0;
  logic [31:0]       branchPredictData = '0;
  Control            fetchDecodeControl = '0;
  logic              instructionRequest;
  logic [31:0]       instructionAddress;
  logic              instructionReady = 1'b0;
  logic              instructionDataValid = 1'b0;
  logic [31:0]       instructionData = '0;
  logic              headValid;
  logic [31:0]       headProgramCounter;
  logic [31:0]       headInstruction;
  FetchDecodePayload fetchDecodePayload;

  always #5 clock = ~clock;

  prefetch_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .controlReset        (controlReset),
    .branchValid         (branchValid),
    .branchData          (branchData),
    .branchPredictValid  (branchPredictValid),
    .branchPredictData   (branchPredictData),
    .fetchDecodeControl  (fetchDecodeControl),
    .instructionRequest  (instructionRequest),
    .instructionAddress  (instructionAddress),
    .instructionReady    (instructionReady),
    .instructionDataValid(instructionDataValid),
    .instructionData     (instructionData),
    .headValid           (headValid),
    .headProgramCounter  (headProgramCounter),
    .headInstruction     (headInstruction),
    .fetchDecodePayload  (fetchDecodePayload)
  );

  typedef struct {
    logic [31:0] address;
    int          due;
  } MemRequest;

  MemRequest         pending[$];
  FetchQueueEntry    modelQueue[$];
  logic [31:0]       modelFetchPC = resetVector;
  logic [31:0]       modelResponsePC = resetVector;
  int                modelOutstanding = 0;
  int                modelDiscard = 0;
  FetchDecodePayload modelPayload = '0;

  int          cycle = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          checksEnabled = 0;
  bit          vReset = 0, vCtrl = 0, vBranch = 0, vPredict = 0, vFlush = 0;
  bit          vStall = 0, vReady = 1, randomDelay = 0;
  logic [31:0] vBranchData = '0, vPredictData = '0;
  int          latMin = 1, latMax = 1;

  function automatic logic [31:0] instrOf(input logic [31:0] address);
    return (address * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cycle, actual, expected);
    end
  endtask

  task automatic checkOutput(input bit expReq, input bit expHeadValid, input FetchQueueEntry head);
    if (!checksEnabled) return;
    checkWord("instructionRequest", 32'(instructionRequest), 32'(expReq));
    if (expReq) checkWord("instructionAddress", instructionAddress, modelFetchPC);
    checkWord("headValid", 32'(headValid), 32'(expHeadValid));
    if (expHeadValid) begin
      checkWord("headProgramCounter", headProgramCounter, head.programCounter);
      checkWord("headInstruction", headInstruction, head.instruction);
    end
    checkWord("payloadValid", 32'(fetchDecodePayload.valid), 32'(modelPayload.valid));
    checkWord("payloadInstruction", fetchDecodePayload.instruction, modelPayload.instruction);
    checkWord("payloadPC", fetchDecodePayload.programCounter, modelPayload.programCounter);
    checkWord("payloadPCPlus4", fetchDecodePayload.programCounterPlus4, modelPayload.programCounterPlus4);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus();
    logic           dv;
    logic [31:0]    data;
    bit             expReq, expHeadValid, predictTaken, redirect, accept;
    logic [31:0]    target;
    FetchQueueEntry head;
    dv = 1'b0;
    data = '0;
    if (vReset) pending.delete();
    else if (pending.size() > 0 && pending[0].due <= cycle && !(randomDelay && $urandom_range(3) == 0)) begin
      dv = 1'b1;
      data = instrOf(pending[0].address);
      void'(pending.pop_front());
    end
    reset = vReset;
    controlReset = vCtrl;
    branchValid = vBranch;
    branchData = vBranchData;
    branchPredictValid = vPredict;
    branchPredictData = vPredictData;
    fetchDecodeControl = '{stall: vStall, flush: vFlush};
    instructionReady = vReady;
    instructionDataValid = dv;
    instructionData = data;
    #1;
    expHeadValid = modelQueue.size() > 0;
    head = expHeadValid ? modelQueue[0] : '0;
    predictTaken = !vCtrl && !vBranch && vPredict && expHeadValid && !vStall;
    redirect = vCtrl || vBranch || predictTaken;
    target = vCtrl ? trapVector : (vBranch ? vBranchData : vPredictData);
    expReq = !vReset && !redirect && (modelOutstanding + modelQueue.size() < DEPTH);
    accept = expReq && vReady;
    checkOutput(expReq, expHeadValid, head);
    if (vReset) begin
      modelFetchPC = resetVector;
      modelResponsePC = resetVector;
      modelOutstanding = 0;
      modelDiscard = 0;
      modelQueue.delete();
      modelPayload = '0;
    end else begin
      if (accept) pending.push_back('{address: modelFetchPC, due: cycle + int'($urandom_range(latMax, latMin))});
      if (vCtrl) modelPayload = '0;
      else if (vFlush) modelPayload.valid = 1'b0;
      else if (!vStall) begin
        if (expHeadValid) begin
          modelPayload = '{valid: 1'b1, instruction: head.instruction,
                           programCounter: head.programCounter,
                           programCounterPlus4: head.programCounter + 32'd4};
          void'(modelQueue.pop_front());
        end else modelPayload.valid = 1'b0;
      end
      if (dv) modelOutstanding--;
      if (redirect) begin
        modelQueue.delete();
        modelFetchPC = target;
        modelResponsePC = target;
        modelDiscard = modelOutstanding;
      end else begin
        if (dv) begin
          if (modelDiscard > 0) modelDiscard--;
          else begin
            modelQueue.push_back('{instruction: data, programCounter: modelResponsePC});
            modelResponsePC += 32'd4;
          end
        end
        if (accept) begin
          modelFetchPC += 32'd4;
          modelOutstanding++;
        end
      end
    end
    @(posedge clock);
    cycle++;
    @(negedge clock);
    vReset = 0; vCtrl = 0; vBranch = 0; vPredict = 0; vFlush = 0;
    reset = 1'b0;
    controlReset = 1'b0;
    branchValid = 1'b0;
    branchPredictValid = 1'b0;
    instructionDataValid = 1'b0;
    fetchDecodeControl = '{stall: vStall, flush: 1'b0};
    #1;
  endtask

  task automatic resetAndCheck();
    vStall = 0; vReady = 1; randomDelay = 0;
    vReset = 1; applyStimulus();
    vReset = 1; applyStimulus();
    reset = 1'b1;
    #1;
    checkWord("resetRequest", 32'(instructionRequest), 32'd0);
    reset = 1'b0;
    #1;
    checkWord("resetHeadValid", 32'(headValid), 32'd0);
    checkWord("resetHeadPC", headProgramCounter, 32'd0);
    checkWord("resetHeadInstruction", headInstruction, 32'd0);
    checkWord("resetPayloadValid", 32'(fetchDecodePayload.valid), 32'd0);
    checkWord("resetPayloadPC", fetchDecodePayload.programCounter, 32'd0);
    checkWord("resetFirstAddress", instructionAddress, resetVector);
    checksEnabled = 1;
  endtask

  task automatic waitPayload(input string name, input logic [31:0] wantPC, input int bound);
    int n = 0;
    while (fetchDecodePayload.valid !== 1'b1 && n < bound) begin
      applyStimulus();
      n++;
    end
    if (fetchDecodePayload.valid !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no valid payload within %0d cycles, got valid %b, want 1", name, bound, fetchDecodePayload.valid);
    end else checkWord(name, fetchDecodePayload.programCounter, wantPC);
  endtask

  initial begin
    // Straight-line run with 2-cycle memory: payload PCs appear one per cycle from the 4th cycle.
    resetAndCheck();
    latMin = 2; latMax = 2;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      if (k >= 3) begin
        checkWord("straightValid", 32'(fetchDecodePayload.valid), 32'd1);
        checkWord("straightPC", fetchDecodePayload.programCounter, resetVector + 32'(4 * (k - 3)));
      end
    end

    // Long decode stall: credits run out, then the queue drains in order.
    resetAndCheck();
    latMin = 1; latMax = 1; vStall = 1;
    repeat (10) applyStimulus();
    checkWord("stallRequest", 32'(instructionRequest), 32'd0);
    checkWord("stallHeadPC", headProgramCounter, resetVector);
    checkWord("stallPayloadValid", 32'(fetchDecodePayload.valid), 32'd0);
    vStall = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkWord("stallDrainPC", fetchDecodePayload.programCounter, resetVector + 32'(4 * k));
    end

    // Branch with three requests in flight: all three responses must be discarded.
    resetAndCheck();
    latMin = 5; latMax = 5;
    repeat (3) applyStimulus();
    vBranch = 1; vBranchData = 32'h100; vFlush = 1;
    applyStimulus();
    checkWord("branchRequest", 32'(instructionRequest), 32'd1);
    checkWord("branchAddress", instructionAddress, 32'h100);
    waitPayload("branchFirstPC", 32'h100, 30);

    // Prediction on head 0x40: head goes to decode, rest of the queue is dropped.
    resetAndCheck();
    latMin = 1; latMax = 1;
    vBranch = 1; vBranchData = 32'h40; vFlush = 1;
    applyStimulus();
    vStall = 1;
    repeat (6) applyStimulus();
    checkWord("predictHeadPC", headProgramCounter, 32'h40);
    vStall = 0; vPredict = 1; vPredictData = 32'h200;
    applyStimulus();
    checkWord("predictPayloadPC", fetchDecodePayload.programCounter, 32'h40);
    checkWord("predictQueueCleared", 32'(headValid), 32'd0);
    applyStimulus();
    waitPayload("predictNextPC", 32'h200, 20);

    // Trap redirect colliding with a response and a branch.
    resetAndCheck();
    latMin = 2; latMax = 2;
    repeat (5) applyStimulus();
    checkWord("trapPrePayloadPC", fetchDecodePayload.programCounter, resetVector + 32'd4);
    vCtrl = 1; vBranch = 1; vBranchData = 32'h300;
    applyStimulus();
    checkWord("trapPayloadValid", 32'(fetchDecodePayload.valid), 32'd0);
    checkWord("trapPayloadInstruction", fetchDecodePayload.instruction, 32'd0);
    checkWord("trapPayloadPC", fetchDecodePayload.programCounter, 32'd0);
    checkWord("trapAddress", instructionAddress, trapVector);
    waitPayload("trapFirstPC", trapVector, 20);

    // Reset with two requests outstanding; memory stays idle across it.
    resetAndCheck();
    latMin = 3; latMax = 3;
    repeat (2) applyStimulus();
    vReset = 1;
    applyStimulus();
    checkWord("midResetHeadValid", 32'(headValid), 32'd0);
    checkWord("midResetPayloadValid", 32'(fetchDecodePayload.valid), 32'd0);
    checkWord("midResetRequest", 32'(instructionRequest), 32'd1);
    checkWord("midResetAddress", instructionAddress, resetVector);
    waitPayload("midResetFirstPC", resetVector, 20);

    // Randomized traffic.
    randomDelay = 1; latMin = 1; latMax = 4;
    for (int i = 0; i < 4000; i++) begin
      vReset = ($urandom_range(499) == 0);
      vCtrl = ($urandom_range(79) == 0);
      vBranch = ($urandom_range(29) == 0);
      vBranchData = $urandom() & 32'h0000_0FFC;
      vPredict = ($urandom_range(7) == 0);
      vPredictData = $urandom() & 32'h0000_0FFC;
      vFlush = vBranch ? ($urandom_range(3) != 0) : ($urandom_range(19) == 0);
      if ($urandom_range(11) == 0) vStall = !vStall;
      vReady = ($urandom_range(3) != 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

endmodule
